// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (oversampled, start/stop validation) feeding a
// circular receive FIFO with a valid/ready read port.
// Optional build macro UART_RX_PARITY_EN: adds an even-parity bit (8E1 frame);
// when undefined the frame is 8N1.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_RX,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    logic          sync1, rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitidx, bitidx_n;
    logic [7:0]    shreg, shreg_n;
    logic          push_req, ferr_req;
`ifdef UART_RX_PARITY_EN
    logic          par_err, par_err_n;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
    logic [AW:0]   count, count_n;
    logic          pop, full, wr_en, drop;

    // Two-flop synchronizer; idles high so reset looks like an idle line
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_RX;
            rx_s  <= sync1;
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            shreg  <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            bitidx <= bitidx_n;
            shreg  <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_err <= par_err_n;
`endif
        end
    end

    // Receiver next-state: sample at cnt==0, reload cnt on every transition
    always_comb begin
        state_n  = state;
        cnt_n    = (cnt != '0) ? cnt - 1'b1 : cnt;
        bitidx_n = bitidx;
        shreg_n  = shreg;
        push_req = 1'b0;
        ferr_req = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_n = par_err;
`endif
        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cnt_n   = CNT_HALF;
                end
            end
            S_START: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n  = S_DATA;
                        cnt_n    = CNT_FULL;
                        bitidx_n = '0;
`ifdef UART_RX_PARITY_EN
                        par_err_n = 1'b0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (cnt == '0) begin
                    shreg_n  = {rx_s, shreg[7:1]};
                    cnt_n    = CNT_FULL;
                    bitidx_n = bitidx + 3'd1;
                    if (bitidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == '0) begin
                    par_err_n = rx_s ^ (^shreg);
                    cnt_n     = CNT_FULL;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == '0) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        ferr_req = 1'b1;
                        state_n  = S_BREAK;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        if (par_err) ferr_req = 1'b1;
                        else         push_req = 1'b1;
`else
                        push_req = 1'b1;
`endif
                        state_n = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        pop      = rx_valid && rx_ready;
        full     = (count == DEPTH_LVL);
        wr_en    = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_n  = count;
        if (wr_en && !pop)      count_n = count + 1'b1;
        else if (!wr_en && pop) count_n = count - 1'b1;
    end

    // FIFO storage (no reset needed: pointers define what is valid)
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers and registered outputs; head forwards a same-cycle write to its slot
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rd_ptr    <= rd_ptr_n;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            count     <= count_n;
            rx_valid  <= (count_n != '0);
            rx_data   <= (wr_en && (wr_ptr == rd_ptr_n)) ? shreg : mem[rd_ptr_n];
            frame_err <= ferr_req;
            overrun   <= drop;
        end
    end

    assign fifo_level = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4). Expected bytes
// are queued when a frame is driven and popped when the consumer accepts one.
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // edges from the start-bit drive edge to the stop-bit sample edge
    localparam int STOP_EDGE = 3 + CPB / 2 + CPB * (NBITS - 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_RX;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [7:0] exp_q [$];
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_RX    (uart_RX),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit expect_push);
        logic [NBITS-1:0] bits;
        if (expect_push) exp_q.push_back(b);
`ifdef UART_RX_PARITY_EN
        bits = {1'b1, (^b) ^ par_flip, b, 1'b0};
`else
        bits = {1'b1, b, 1'b0};
`endif
        for (int i = 0; i < NBITS; i++) begin
            @(posedge clk);
            #1 uart_RX = bits[i];
            repeat (CPB - 1) @(posedge clk);
        end
    endtask

    // Pulse counters and scoreboard consumer
    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (exp_q.size() == 0) check_eq("pop_without_expected", 32'(exp_q.size()), 1);
            else check_eq("rx_data_pop", rx_data, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr_base;
        int ovr_base;
        rst = 1'b1; uart_RX = 1'b1; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        check_eq("reset_rx_valid", rx_valid, 0);
        check_eq("reset_rx_data", rx_data, 0);
        check_eq("reset_frame_err", frame_err, 0);
        check_eq("reset_overrun", overrun, 0);
        check_eq("reset_level", fifo_level, 0);
        idle(5);

        // single byte, exact rx_valid timing
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1 check_eq("t1_valid_before", rx_valid, 0);
                @(posedge clk);
                #1 check_eq("t1_valid_after", rx_valid, 1);
                check_eq("t1_data", rx_data, 8'hA5);
                check_eq("t1_level", fifo_level, 1);
            end
        join
        idle(20);
        check_eq("t1_no_ferr", ferr_cnt, 0);
        check_eq("t1_no_ovr", ovr_cnt, 0);
        rx_ready = 1'b1;
        idle(5);
        check_eq("t1_drained", rx_valid, 0);
        check_eq("t1_queue", exp_q.size(), 0);

        // fill past capacity: fifth byte dropped
        rx_ready = 1'b0;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
        send_frame(8'h55, 1'b0);
        idle(20);
        check_eq("t2_level_full", fifo_level, DEPTH);
        check_eq("t2_overrun", ovr_cnt, 1);
        check_eq("t2_head", rx_data, 8'h00);
        rx_ready = 1'b1;
        idle(10);
        check_eq("t2_drained", rx_valid, 0);
        check_eq("t2_queue", exp_q.size(), 0);

        // break: line low for 20 bit times
        ferr_base = ferr_cnt;
        @(posedge clk);
        #1 uart_RX = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1 uart_RX = 1'b1;
        idle(3 * CPB);
        check_eq("t3_one_ferr", ferr_cnt - ferr_base, 1);
        check_eq("t3_no_push", fifo_level, 0);
        send_frame(8'h12, 1'b1);
        idle(20);
        check_eq("t3_queue", exp_q.size(), 0);
        check_eq("t3_ferr_after", ferr_cnt - ferr_base, 1);

        // 4-cycle glitch: false start
        ferr_base = ferr_cnt;
        @(posedge clk);
        #1 uart_RX = 1'b0;
        repeat (4) @(posedge clk);
        #1 uart_RX = 1'b1;
        idle(4 * CPB);
        check_eq("t4_no_ferr", ferr_cnt - ferr_base, 0);
        check_eq("t4_no_push", rx_valid, 0);
        send_frame(8'h5A, 1'b1);
        idle(20);
        check_eq("t4_queue", exp_q.size(), 0);

        // full FIFO with push and pop in the same cycle
        ovr_base = ovr_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(20);
        check_eq("t5_level_full", fifo_level, DEPTH);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 check_eq("t5_level_kept", fifo_level, DEPTH);
            end
        join
        idle(20);
        check_eq("t5_no_overrun", ovr_cnt - ovr_base, 0);
        check_eq("t5_queue", exp_q.size(), 0);
        check_eq("t5_drained", rx_valid, 0);

        // reset in the middle of data bit 3
        ferr_base = ferr_cnt;
        fork
            send_frame(8'hF8, 1'b0);
            begin
                repeat (4 * CPB + CPB / 2 + 1) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                check_eq("t6_rx_valid", rx_valid, 0);
                check_eq("t6_rx_data", rx_data, 0);
                check_eq("t6_frame_err", frame_err, 0);
                check_eq("t6_overrun", overrun, 0);
                check_eq("t6_level", fifo_level, 0);
            end
        join
        idle(20);
        check_eq("t6_no_ferr", ferr_cnt - ferr_base, 0);
        check_eq("t6_no_push", rx_valid, 0);
        send_frame(8'hC3, 1'b1);
        idle(20);
        check_eq("t6_queue", exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
        // parity error then good parity
        ferr_base = ferr_cnt;
        par_flip = 1'b1;
        send_frame(8'h03, 1'b0);
        idle(20);
        check_eq("t7_par_ferr", ferr_cnt - ferr_base, 1);
        check_eq("t7_no_push", rx_valid, 0);
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1);
        idle(20);
        check_eq("t7_queue", exp_q.size(), 0);
        check_eq("t7_ferr_after", ferr_cnt - ferr_base, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
